// File: rtl/mmio_fifo_csr.sv
// CCI-P MMIO CSR block: DFH/AFU-ID, scratch registers and a host-visible FIFO.
// Optional FIFO watermark register and flag enabled by MMIO_FIFO_WATERMARK_EN.
module mmio_fifo_csr #(
  parameter int             DATA_W        = 64,
  parameter int             FIFO_DEPTH    = 16,
  parameter int             NUM_USER_REGS = 4,
  parameter logic [15:0]    USER_BASE     = 16'h0020,
  parameter logic [15:0]    FIFO_BASE     = 16'h0040,
  parameter logic [127:0]   AFU_ID        = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mmio_wr_valid,
  input  logic              mmio_rd_valid,
  input  logic [15:0]       mmio_addr,
  input  logic [8:0]        mmio_tid,
  input  logic [DATA_W-1:0] mmio_wdata,
  output logic              rd_rsp_valid,
  output logic [8:0]        rd_rsp_tid,
  output logic [DATA_W-1:0] rd_rsp_data,
  output logic              fifo_wm_hit
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [63:0] DFH =
    {4'b0001, 8'b0, 4'b0, 7'b0, 1'b1, 24'b0, 4'b0, 12'b0};

  localparam logic [15:0] A_DATA = FIFO_BASE;
  localparam logic [15:0] A_STAT = FIFO_BASE + 16'd2;
  localparam logic [15:0] A_CTRL = FIFO_BASE + 16'd4;

  logic [DATA_W-1:0] user_q [NUM_USER_REGS];
  logic [DATA_W-1:0] mem    [FIFO_DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_q, count_nxt;
  logic          ovf_q, udf_q;

  logic              hit_data, hit_stat;
  logic              pop_req, push_req;
  logic              ctrl_wr, flush, clr;
  logic              empty, full;
  logic              pop_ok, push_ok;
  logic              user_hit;
  logic [DATA_W-1:0] user_rdata;
  logic [DATA_W-1:0] rdata;

  assign hit_data = mmio_addr == A_DATA;
  assign hit_stat = mmio_addr == A_STAT;

  assign pop_req  = mmio_rd_valid && hit_data;
  assign push_req = mmio_wr_valid && hit_data;
  assign ctrl_wr  = mmio_wr_valid && (mmio_addr == A_CTRL);
  assign flush    = ctrl_wr && mmio_wdata[0];
  assign clr      = ctrl_wr && mmio_wdata[1];

  assign empty = count_q == '0;
  assign full  = count_q == CW'(FIFO_DEPTH);

  // A pop frees the slot a same-cycle push into a full FIFO needs.
  assign pop_ok  = pop_req && !empty;
  assign push_ok = push_req && (!full || pop_ok) && !flush;

  always_comb begin
    count_nxt = count_q + CW'(push_ok) - CW'(pop_ok);
    if (flush) count_nxt = '0;
  end

  always_comb begin
    user_hit   = 1'b0;
    user_rdata = '0;
    for (int i = 0; i < NUM_USER_REGS; i++) begin
      if (mmio_addr == USER_BASE + 16'(2 * i)) begin
        user_hit   = 1'b1;
        user_rdata = user_q[i];
      end
    end
  end

`ifdef MMIO_FIFO_WATERMARK_EN
  localparam logic [15:0] A_WM = FIFO_BASE + 16'd6;

  logic        hit_wm;
  logic [15:0] wm_q, wm_nxt;
  logic        wm_hit_q;

  assign hit_wm = mmio_addr == A_WM;

  always_comb begin
    wm_nxt = wm_q;
    if (mmio_wr_valid && hit_wm) wm_nxt = mmio_wdata[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wm_q     <= '0;
      wm_hit_q <= 1'b0;
    end else begin
      wm_q     <= wm_nxt;
      wm_hit_q <= (16'(count_nxt) >= wm_nxt) && (wm_nxt != '0);
    end
  end

  assign fifo_wm_hit = wm_hit_q;
`else
  assign fifo_wm_hit = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      mmio_addr == 16'h0000: rdata = DFH;
      mmio_addr == 16'h0002: rdata = AFU_ID[63:0];
      mmio_addr == 16'h0004: rdata = AFU_ID[127:64];
      user_hit:              rdata = user_rdata;
      hit_data:              rdata = empty ? '0 : mem[rd_ptr];
      hit_stat:              rdata = {44'b0, udf_q, ovf_q, full, empty,
                                      16'(count_q)};
`ifdef MMIO_FIFO_WATERMARK_EN
      hit_wm:                rdata = {48'b0, wm_q};
`endif
      default:               rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= mmio_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_USER_REGS; i++) user_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_USER_REGS; i++) begin
        if (mmio_wr_valid && mmio_addr == USER_BASE + 16'(2 * i))
          user_q[i] <= mmio_wdata;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      end
      if (clr) begin
        ovf_q <= 1'b0;
        udf_q <= 1'b0;
      end
      if (push_req && full && !pop_ok) ovf_q <= 1'b1;
      if (pop_req && empty)            udf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_rsp_valid <= 1'b0;
      rd_rsp_tid   <= '0;
      rd_rsp_data  <= '0;
    end else begin
      rd_rsp_valid <= mmio_rd_valid;
      if (mmio_rd_valid) begin
        rd_rsp_tid  <= mmio_tid;
        rd_rsp_data <= rdata;
      end
    end
  end

endmodule

// File: doc/mmio_fifo_csr.md
Name: mmio_fifo_csr

Overview:
- Parametrised MMIO register block for CCI-P AFUs.
- Decodes host MMIO reads and writes. Holds the mandatory DFH and AFU-ID registers, NUM_USER_REGS read/write scratch registers, and a host-visible FIFO of DATA_W-bit entries with status and control registers.
- Sits between the CCI-P Rx c0 MMIO fields and the Tx c2 read-response fields. The parent unpacks and packs the CCI-P structs.

Parameters:
- DATA_W, 64: data width. FIFO entry and register width; must be 64.
- FIFO_DEPTH, 16: FIFO entries. Power of two, 2..1024.
- NUM_USER_REGS, 4: number of scratch registers, 1..16.
- USER_BASE, 16'h0020: address of user register 0.
- FIFO_BASE, 16'h0040: base address of the FIFO register group.
- AFU_ID, 128'h0: value returned at ID_L/ID_H.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- mmio_wr_valid  in  1  MMIO write strobe, one cycle
- mmio_rd_valid  in  1  MMIO read strobe, one cycle
- mmio_addr  in  16  address in 4-byte units; 64-bit registers sit at even addresses
- mmio_tid  in  9  transaction ID of the read
- mmio_wdata  in  64  write data
- rd_rsp_valid  out  1  read-response strobe
- rd_rsp_tid  out  9  echoed TID
- rd_rsp_data  out  64  read data
- fifo_wm_hit  out  1  watermark flag (see Optional Feature)

Behaviour:
- Reset: clk is the only clock. rst is asynchronous and active-high.
  - Outputs: rd_rsp_valid=0, rd_rsp_tid=0, rd_rsp_data=0, fifo_wm_hit=0.
  - Internal state: user registers, FIFO pointers/count, sticky flags and the watermark register all cleared.
  - A read accepted the cycle before rst asserts gets no response.
- Address map (reads of unmapped addresses return 0; writes to unmapped addresses are ignored; odd addresses are unmapped):
  - 0x0000 DFH, read-only: {4'b0001, 8'b0, 4'b0, 7'b0, 1'b1, 24'b0, 4'b0, 12'b0}.
  - 0x0002 AFU_ID[63:0], read-only.
  - 0x0004 AFU_ID[127:64], read-only.
  - 0x0006 and 0x0008 read 0.
  - USER_BASE+2*i, i<NUM_USER_REGS: scratch register i, read/write.
  - FIFO_BASE+0 DATA:
    - Write pushes mmio_wdata.
    - Read returns the head entry and pops it.
  - FIFO_BASE+2 STATUS, read-only:
    - [15:0] count
    - [16] empty
    - [17] full
    - [18] overflow (sticky)
    - [19] underflow (sticky)
    - [63:20] zero
  - FIFO_BASE+4 CTRL, write-only (reads 0):
    - Bit0=1 flushes the FIFO: pointers and count go to 0; entry contents need not be cleared.
    - Bit1=1 clears both sticky flags.
- Read timing:
  - Latency is exactly 1 cycle: rd_rsp_valid pulses high for one cycle, the cycle after mmio_rd_valid.
  - rd_rsp_tid and rd_rsp_data are registered in the same edge.
  - rd_rsp_data and rd_rsp_tid hold their last value while rd_rsp_valid=0.
  - Every read produces exactly one response; back-to-back reads give back-to-back responses.
- Write timing: a write takes effect on the edge where mmio_wr_valid is high; it is visible to a read issued the next cycle.
- Same-cycle read and write: both are processed.
  - A read returns state from before the same-cycle write.
  - Push and pop in one cycle:
    - count=0: the pop underflows (returns 0, underflow set) and the push succeeds; count becomes 1.
    - count=FIFO_DEPTH: both succeed; count is unchanged and overflow is not set.
    - Otherwise: both succeed and count is unchanged.
- FIFO full: a push is dropped, overflow is set, and the pointers are unchanged.
- FIFO empty: a pop returns 0, underflow is set, and the pointers are unchanged.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits, zero-extended into STATUS[15:0].
- Flush in the same cycle as a push: the flush wins and the push is discarded.

Optional Feature:
- Macro: MMIO_FIFO_WATERMARK_EN.
- Defined:
  - FIFO_BASE+6 is a read/write WATERMARK register; bits [15:0] are used, upper bits read 0; reset 0.
  - fifo_wm_hit is registered and equals (count >= WATERMARK) && (WATERMARK != 0), based on the post-update count, so it has 1-cycle latency.
- Undefined:
  - FIFO_BASE+6 is unmapped (reads return 0).
  - fifo_wm_hit is tied to 0.

Test Plan:
- After reset, read 0x0000, 0x0002, 0x0004, 0x0006 with TIDs 1..4 -> four back-to-back rd_rsp_valid pulses, each 1 cycle after its request, with the TIDs echoed; data = DFH 64'h1000_0100_0000_0000, then AFU_ID[63:0], AFU_ID[127:64], 0.
- Write 64'hDEAD_BEEF to 0x0020 and 64'h1234 to 0x0026, then read both and read 0x0028 -> DEAD_BEEF, 1234, 0 (0x0028 is unmapped with NUM_USER_REGS=4).
- Push 1..16 to 0x0040, push 17, read STATUS -> count=16, full=1, overflow=1; then pop 16 times -> data 1..16 in order, STATUS count=0 and empty=1.
- Pop while empty -> data 0, underflow=1; write CTRL=2 -> STATUS reads 64'h1_0000 (empty only).
- With FIFO full, issue a same-cycle push of 99 and a pop -> pop returns the head, count stays 16, overflow=0; then push 3 entries and write CTRL=1 -> count=0, and a pop returns 0.
- With MMIO_FIFO_WATERMARK_EN: WATERMARK=4, push 3 -> fifo_wm_hit=0; 4th push -> fifo_wm_hit=1 on the next cycle; pop 1 -> fifo_wm_hit=0.
- Assert rst during a pending read -> no response; all outputs and registers are 0.
